// File: rtl/router_pkt_tx_pkg.sv
// Shared router package.
// Purpose: common widths, limits, FSM state encoding and small helpers used by
// the router transmit blocks.
//   DATA_W       - router byte width
//   CNT_W        - width of the packet length / buffer count
//   DEPTH        - buffer storage entries
//   MAX_LEN      - largest payload length a packet may carry
//   ILLEGAL_ADDR - destination code that has no router port behind it
package router_pkt_tx_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 6;
  localparam int DEPTH  = 64;

  localparam logic [CNT_W-1:0] MAX_LEN      = 6'd63;
  localparam logic [1:0]       ILLEGAL_ADDR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_t;

  // Header byte: payload length in the upper six bits, destination below.
  function automatic logic [DATA_W-1:0] make_header(input logic [CNT_W-1:0] len,
                                                    input logic [1:0]       addr);
    return {len, addr};
  endfunction

  // Parity as transmitted; inversion is the deliberate error-injection path.
  function automatic logic [DATA_W-1:0] final_parity(input logic [DATA_W-1:0] acc,
                                                     input logic              inv);
    return inv ? ~acc : acc;
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Router transmit interface.
// Purpose: bundles the host-side write/command signals and the router-side
// byte stream of router_pkt_tx.
//   wr_en/wr_data           - payload byte write
//   dest_addr/start/inject_err - packet launch command
//   busy                    - router back-pressure
//   data_out/pkt_valid      - byte stream to the router
//   tx_idle/tx_done/cfg_err/wr_err - status
// master: the transmitter; slave: the environment driving/observing it.
interface router_pkt_tx_if;
  import router_pkt_tx_pkg::*;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        dest_addr;
  logic              start;
  logic              inject_err;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              pkt_valid;
  logic              tx_idle;
  logic              tx_done;
  logic              cfg_err;
  logic              wr_err;

  modport master (
    input  wr_en, wr_data, dest_addr, start, inject_err, busy,
    output data_out, pkt_valid, tx_idle, tx_done, cfg_err, wr_err
  );

  modport slave (
    output wr_en, wr_data, dest_addr, start, inject_err, busy,
    input  data_out, pkt_valid, tx_idle, tx_done, cfg_err, wr_err
  );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// Packet payload buffer (router_tx_buf).
// Purpose: 64x8 storage written sequentially, with a prefetching read port so
// the next byte to transmit is always already registered on rd_data_o.
//   clk_i, rst_i  - clock, synchronous active-high reset (control only)
//   wr_en_i       - store wr_data_i at index count, then count+1
//   wr_data_i     - byte to store
//   clr_i         - clear count (packet finished)
//   rd_start_i    - load entry 0 into rd_data_o
//   rd_adv_i      - current rd_data_o consumed; load the following entry
//   rd_data_o     - registered next byte to transmit
//   count_o       - number of stored bytes
module router_tx_buf
  import router_pkt_tx_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  input  logic              rd_start_i,
  input  logic              rd_adv_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  rd_addr;
  logic              rd_load;

  // rd_ptr_q names the entry sitting in rd_data_q; advancing fetches the one
  // after it so the FSM never waits on the synchronous read.
  assign rd_load = rd_start_i | rd_adv_i;
  assign rd_addr = rd_start_i ? '0 : rd_ptr_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[count_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_load) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (clr_i) begin
        count_q <= '0;
      end else if (wr_en_i) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (rd_load) begin
        rd_ptr_q <= rd_addr;
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter.
// Purpose: buffers up to 63 payload bytes, then on start sends
// header {len, addr}, the payload and an XOR parity byte to the router,
// honouring busy back-pressure, followed by GAP_CYCLES idle cycles.
//   clock  - sole clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - router_pkt_tx_if.master (writes, command, byte stream, status)
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input logic             clock,
  input logic             reset,
  router_pkt_tx_if.master bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tx_state_t         state_q;
  logic [DATA_W-1:0] data_out_q;
  logic              pkt_valid_q;
  logic              tx_idle_q;
  logic              tx_done_q;
  logic              cfg_err_q;
  logic              wr_err_q;
  logic [CNT_W-1:0]  rem_q;
  logic [DATA_W-1:0] par_q;
  logic              inj_q;
  logic [GAP_W-1:0]  gap_q;

  logic              in_idle;
  logic              start_ok;
  logic              wr_ok;
  logic              wr_drop;
  logic              rd_adv;
  logic              buf_clr;
  logic              last_pay;
  logic [DATA_W-1:0] par_d;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;

  assign in_idle  = (state_q == ST_IDLE);
  assign start_ok = in_idle & bus.start & (count != '0) & (bus.dest_addr != ILLEGAL_ADDR);
  // An accepted start owns the cycle; a simultaneous write would change len.
  assign wr_ok    = bus.wr_en & in_idle & (count < MAX_LEN) & ~start_ok;
  assign wr_drop  = bus.wr_en & ~wr_ok;
  assign last_pay = (rem_q == CNT_W'(1));
  assign par_d    = par_q ^ data_out_q;

  // The header consumes nothing from the buffer but moves the prefetched
  // byte 0 out, so the read port advances on header and on every non-final
  // payload acceptance.
  assign rd_adv  = ~bus.busy & ((state_q == ST_HEADER) | ((state_q == ST_PAYLOAD) & ~last_pay));
  assign buf_clr = ~bus.busy & (state_q == ST_PARITY);

  router_tx_buf u_buf (
    .clk_i      (clock),
    .rst_i      (reset),
    .wr_en_i    (wr_ok),
    .wr_data_i  (bus.wr_data),
    .clr_i      (buf_clr),
    .rd_start_i (start_ok),
    .rd_adv_i   (rd_adv),
    .rd_data_o  (rd_data),
    .count_o    (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      tx_idle_q   <= 1'b1;
      tx_done_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      rem_q       <= '0;
      par_q       <= '0;
      inj_q       <= 1'b0;
      gap_q       <= '0;
    end else begin
      tx_done_q <= 1'b0;
      cfg_err_q <= 1'b0;
      wr_err_q  <= wr_drop;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q     <= ST_HEADER;
            data_out_q  <= make_header(count, bus.dest_addr);
            pkt_valid_q <= 1'b1;
            tx_idle_q   <= 1'b0;
            rem_q       <= count;
            inj_q       <= bus.inject_err;
            par_q       <= '0;
          end else if (bus.start) begin
            cfg_err_q <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (!bus.busy) begin
            par_q      <= par_d;
            data_out_q <= rd_data;
            state_q    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!bus.busy) begin
            par_q <= par_d;
            if (last_pay) begin
              data_out_q  <= final_parity(par_d, inj_q);
              pkt_valid_q <= 1'b0;
              state_q     <= ST_PARITY;
            end else begin
              data_out_q <= rd_data;
              rem_q      <= rem_q - CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (!bus.busy) begin
            tx_done_q  <= 1'b1;
            data_out_q <= '0;
            if (GAP_CYCLES == 0) begin
              state_q   <= ST_IDLE;
              tx_idle_q <= 1'b1;
            end else begin
              state_q <= ST_GAP;
              gap_q   <= GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_q   <= ST_IDLE;
            tx_idle_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          data_out_q  <= '0;
          pkt_valid_q <= 1'b0;
          tx_idle_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.tx_idle   = tx_idle_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.wr_err    = wr_err_q;

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles (pkt_valid=0, data_out=0) inserted after each packet's parity byte.
REQ-002 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  in  1  write one payload byte into the internal buffer.
REQ-005 SHALL have port wr_data  in  8  payload byte written when wr_en=1.
REQ-006 SHALL have port dest_addr  in  2  destination port 0..2, sampled on start; 3 is illegal.
REQ-007 SHALL have port start  in  1  request transmission of the buffered packet.
REQ-008 SHALL have port inject_err  in  1  sampled on start; when 1, the transmitted parity byte is bit-inverted.
REQ-009 SHALL have port busy  in  1  router back-pressure; when 1, the current byte is held.
REQ-010 SHALL have port data_out  out  8  registered packet byte to the router.
REQ-011 SHALL have port pkt_valid  out  1  registered; 1 on header and payload bytes, 0 on parity and idle.
REQ-012 SHALL have port tx_idle  out  1  1 while in IDLE.
REQ-013 SHALL have port tx_done  out  1  one-cycle pulse on acceptance of the parity byte.
REQ-014 SHALL have port cfg_err  out  1  one-cycle pulse when start is rejected.
REQ-015 SHALL have port wr_err  out  1  one-cycle pulse when a write is dropped.

Function
REQ-016 SHALL implement FSM states IDLE, HEADER, PAYLOAD, PARITY, GAP.
REQ-017 SHALL accept writes only in IDLE with count<63: byte stored at index count, count incremented; otherwise drop the write and pulse wr_err the next cycle.
REQ-018 SHALL, on start in IDLE with count>=1 and dest_addr!=3, latch addr, len=count and inject_err, then go to HEADER; writes in the same cycle are dropped.
REQ-019 SHALL, on start in IDLE with count=0 or dest_addr=3, pulse cfg_err for one cycle, stay in IDLE and keep the buffer; start outside IDLE is ignored.
REQ-020 SHALL present header {len[5:0], addr[1:0]} with pkt_valid=1 in the cycle after start is accepted.
REQ-021 SHALL treat a byte as accepted at any rising edge in HEADER/PAYLOAD/PARITY where busy=0; while busy=1, data_out and pkt_valid hold.
REQ-022 SHALL present payload bytes in write order, one per accepted edge, with no bubbles; buffer read latency is hidden by prefetch.
REQ-023 SHALL, after the last payload byte is accepted, present parity = XOR of header and all payload bytes (inverted if inject_err was latched) with pkt_valid=0.
REQ-024 SHALL, on parity acceptance, pulse tx_done, clear count to 0 and enter GAP; after GAP_CYCLES cycles enter IDLE, or go directly to IDLE if GAP_CYCLES=0.
REQ-025 SHALL drive data_out=0 and pkt_valid=0 in IDLE and GAP; busy is ignored there.
REQ-026 SHALL keep the parity accumulator 8 bits wide, cleared when start is accepted.

Reset
REQ-027 SHALL, when reset=1 at a clock edge (including mid-packet), force IDLE with count=0, data_out=0, pkt_valid=0, tx_done=0, cfg_err=0, wr_err=0 and tx_idle=1; buffer RAM contents need not be cleared.

Structure
REQ-028 SHALL take FSM state encoding, MAX_LEN=63 and ILLEGAL_ADDR=3 from the shared router package used by the router blocks.
REQ-029 SHALL instantiate one sub-module, router_tx_buf (64x8 storage, write pointer/count, prefetching read port); FSM and parity stay in router_pkt_tx.

Verification
REQ-030 SHALL cover: write 0x11,0x22,0x33; dest_addr=1; start -> data_out 0x0D(pv=1),0x11,0x22,0x33(pv=1), then 0x0D(pv=0); tx_done pulses once; GAP_CYCLES idle cycles; tx_idle=1.
REQ-031 SHALL cover: same packet with busy=1 for 3 cycles while 0x22 is presented -> 0x22 and pv=1 held 4 cycles total, no byte lost or duplicated.
REQ-032 SHALL cover: dest_addr=3 with start, and start with empty buffer -> cfg_err one-cycle pulse each, pkt_valid stays 0.
REQ-033 SHALL cover: 64 writes of 0xA5 -> wr_err on 64th; start with addr=2 -> header 0xFE, 63 payload bytes, parity 0xFE^0xA5=0x5B.
REQ-034 SHALL cover: REQ-030 packet with inject_err=1 -> parity byte 0xF2; then reset asserted during payload -> next cycle data_out=0, pv=0, tx_idle=1, count=0.
